// File: rtl/reg_file_wr_arb_if.sv
// Write-request bundle between writeback sources and the register-file write arbiter.
// Slice i of idx/data belongs to requester i; ready is one-hot or zero.
interface reg_file_wr_arb_if #(
    parameter int NUM_REQ   = 3,
    parameter int REG_WIDTH = 32,
    parameter int IDX_WIDTH = 5
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*IDX_WIDTH-1:0] req_idx;
    logic [NUM_REQ*REG_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;

    modport master (output req_valid, req_idx, req_data, input req_ready);
    modport slave  (input req_valid, req_idx, req_data, output req_ready);
endinterface

// File: rtl/reg_file_wr_arb.sv
// Register-file write arbiter: clears x1..x31 after reset, then round-robin grants one writer per cycle.
// Latency: accepted request appears on rf_wr_* the cycle after the transfer edge.
// Backpressure: ready is held low during clear; in run only the round-robin winner sees ready.
module reg_file_wr_arb #(
    parameter int NUM_REQ   = 3,
    parameter int REG_WIDTH = 32,
    parameter int IDX_WIDTH = 5,
    parameter int REG_COUNT = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg_file_wr_arb_if.slave     req_if,
    output logic                 rf_wr_en,
    output logic [IDX_WIDTH-1:0] rf_wr_index,
    output logic [REG_WIDTH-1:0] rf_wr_data,
    output logic [1:0]           grant_id,
    output logic                 init_done
);
    typedef enum logic {CLEAR, RUN} state_t;

    typedef struct packed {
        logic                 en;
        logic [IDX_WIDTH-1:0] idx;
        logic [REG_WIDTH-1:0] dat;
    } wr_t;

    state_t               state;
    wr_t                  wr_q;
    logic [IDX_WIDTH-1:0] clr_cnt;
    logic [1:0]           last_ptr;
    logic [1:0]           grant_q;
    logic                 done_q;

    logic                 found;
    logic [1:0]           sel;
    logic [IDX_WIDTH-1:0] sel_idx;
    logic [REG_WIDTH-1:0] sel_dat;
    logic [NUM_REQ-1:0]   ready;

    // Two passes: requesters above last_ptr first, then wrap to those at or below it.
    always_comb begin
        found   = 1'b0;
        sel     = last_ptr;
        sel_idx = '0;
        sel_dat = '0;
        ready   = '0;
        if (state == RUN) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req_if.req_valid[i] && (i > int'(last_ptr))) begin
                    found = 1'b1;
                    sel   = 2'(i);
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req_if.req_valid[i] && (i <= int'(last_ptr))) begin
                    found = 1'b1;
                    sel   = 2'(i);
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (found && (sel == 2'(i))) begin
                    ready[i] = 1'b1;
                    sel_idx  = req_if.req_idx[i*IDX_WIDTH +: IDX_WIDTH];
                    sel_dat  = req_if.req_data[i*REG_WIDTH +: REG_WIDTH];
                end
            end
        end
    end

    assign req_if.req_ready = ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CLEAR;
            clr_cnt  <= IDX_WIDTH'(1);
            last_ptr <= 2'(NUM_REQ - 1);
            wr_q     <= '0;
            grant_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    wr_q.en  <= 1'b1;
                    wr_q.idx <= clr_cnt;
                    wr_q.dat <= '0;
                    if (clr_cnt == IDX_WIDTH'(REG_COUNT - 1)) begin
                        state  <= RUN;
                        done_q <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + IDX_WIDTH'(1);
                    end
                end
                RUN: begin
                    if (found) begin
                        // Writes to x0 are consumed but never reach the register file.
                        wr_q.en  <= (sel_idx != '0);
                        wr_q.idx <= sel_idx;
                        wr_q.dat <= sel_dat;
                        grant_q  <= sel;
                        last_ptr <= sel;
                    end else begin
                        wr_q.en <= 1'b0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    assign rf_wr_en    = wr_q.en;
    assign rf_wr_index = wr_q.idx;
    assign rf_wr_data  = wr_q.dat;
    assign grant_id    = grant_q;
    assign init_done   = done_q;
endmodule
